// File: rtl/obc_da_serial_engine_pkg.sv
// Shared definitions for the offset-binary-coded distributed-arithmetic DFT
// serial engine: transform size, default widths, FSM state encoding and the
// slice-counter type for the default sample width.
package obc_pkg;

    localparam int unsigned N_POINTS = 16;
    localparam int unsigned DW_DEF   = 16;
    localparam int unsigned RW_DEF   = 32;
    localparam int unsigned ACCW_DEF = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } obc_da_state_t;

    typedef logic [$clog2(DW_DEF)-1:0] slice_cnt_t;

endpackage

// File: rtl/obc_slice_serializer.sv
// Sixteen parallel-load, right-shift sample registers. The LSB of every
// register forms the current bit-slice, so successive shifts present the
// samples LSB first.
//   clk     : rising-edge clock
//   load    : capture all samples (takes priority over shift)
//   shift   : shift every register right by one bit
//   samples : flattened samples, sample k at [k*DW +: DW]
//   slice   : bit 0 of every register, bit k from sample k
module obc_slice_serializer
    import obc_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                   clk,
    input  logic                   load,
    input  logic                   shift,
    input  logic [N_POINTS*DW-1:0] samples,
    output logic [N_POINTS-1:0]    slice
);

    logic [DW-1:0] sr_q [N_POINTS];
    logic [DW-1:0] sr_d [N_POINTS];

    always_comb begin
        for (int k = 0; k < N_POINTS; k++) begin
            sr_d[k]  = sr_q[k];
            if (load) begin
                sr_d[k] = samples[k*DW +: DW];
            end else if (shift) begin
                sr_d[k] = sr_q[k] >> 1;
            end
            slice[k] = sr_q[k][0];
        end
    end

    // Pure datapath storage: contents are always reloaded before use, so no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_POINTS; k++) begin
            sr_q[k] <= sr_d[k];
        end
    end

endmodule

// File: rtl/obc_da_serial_engine.sv
// Bit-serial driver and shift-accumulator around a DA ROM stage of the
// 16-point DFT. Presents one sample bit-slice per cycle (LSB first) and
// accumulates the ROM partial sum, weighted by 2^b, into one output term.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request a transform (accepted in IDLE or DONE)
//   samples  : 16 flattened samples, sample k at [k*DW +: DW]
//   x_bits   : registered bit-slice to the ROM address inputs
//   m        : registered MSB-slice flag to the ROM stage
//   rom_in   : ROM partial sum for the slice on x_bits (two's complement)
//   busy     : high in LOAD and SHIFT
//   done     : one-cycle pulse when result is updated
//   result   : accumulated term, held until the next transform completes
module obc_da_serial_engine
    import obc_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int RW   = RW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_POINTS*DW-1:0] samples,
    output logic [N_POINTS-1:0]    x_bits,
    output logic                   m,
    input  logic [RW-1:0]          rom_in,
    output logic                   busy,
    output logic                   done,
    output logic [ACCW-1:0]        result
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] B_LAST = CW'(DW - 1);

    function automatic logic signed [ACCW-1:0] sext_rom(input logic [RW-1:0] r);
        return {{(ACCW-RW){r[RW-1]}}, r};
    endfunction

    obc_da_state_t          state_q, state_d;
    logic [CW-1:0]          b_q, b_d;
    logic signed [ACCW-1:0] acc_q, acc_d, acc_sum;
    logic [N_POINTS-1:0]    x_bits_q, x_bits_d;
    logic                   m_q, m_d;
    logic [ACCW-1:0]        result_q, result_d;
    logic                   accept;
    logic                   shift_en;
    logic [N_POINTS-1:0]    slice;

    obc_slice_serializer #(.DW(DW)) u_serializer (
        .clk     (clk),
        .load    (accept),
        .shift   (shift_en),
        .samples (samples),
        .slice   (slice)
    );

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        acc_d    = acc_q;
        x_bits_d = '0;
        m_d      = 1'b0;
        result_d = result_q;
        accept   = 1'b0;
        acc_sum  = acc_q + (sext_rom(rom_in) <<< b_q);
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                    b_d     = '0;
                    acc_d   = '0;
                end
            end
            LOAD: begin
                // First slice goes out registered; b is still 0 here.
                x_bits_d = slice;
                m_d      = (b_q == B_LAST);
                state_d  = SHIFT;
            end
            SHIFT: begin
                acc_d = acc_sum;
                if (b_q == B_LAST) begin
                    state_d  = DONE;
                    result_d = acc_sum;
                end else begin
                    b_d      = b_q + 1'b1;
                    x_bits_d = slice;
                    m_d      = (b_d == B_LAST);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign shift_en = (state_q == LOAD) || (state_q == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            b_q      <= '0;
            acc_q    <= '0;
            x_bits_q <= '0;
            m_q      <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            x_bits_q <= x_bits_d;
            m_q      <= m_d;
            result_q <= result_d;
        end
    end

    assign x_bits = x_bits_q;
    assign m      = m_q;
    assign busy   = (state_q == LOAD) || (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_obc_da_serial_engine.sv
module tb_obc_da_serial_engine;
    import obc_pkg::*;

    localparam int DW   = 16;
    localparam int RW   = 32;
    localparam int ACCW = 48;
    localparam int NP   = 16;
    localparam int LAT  = DW + 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [NP*DW-1:0]    samples;
    logic [NP-1:0]       x_bits;
    logic                m;
    logic [RW-1:0]       rom_in;
    logic                busy;
    logic                done;
    logic [ACCW-1:0]     result;

    always #5 clk = ~clk;

    obc_da_serial_engine #(.DW(DW), .RW(RW), .ACCW(ACCW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .samples (samples),
        .x_bits  (x_bits),
        .m       (m),
        .rom_in  (rom_in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // ROM stand-in: 0 = constant, 1 = x_bits zero-extended, 2 = popcount(x_bits)
    int            rom_mode;
    logic [RW-1:0] rom_const;

    function automatic logic [RW-1:0] rom_model(input int mode, input logic [RW-1:0] c,
                                                input logic [NP-1:0] xb);
        case (mode)
            0:       return c;
            1:       return RW'(xb);
            default: return RW'($countones(xb));
        endcase
    endfunction

    assign rom_in = rom_model(rom_mode, rom_const, x_bits);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected result and acceptance cycle pushed at start.
    typedef struct {
        logic [ACCW-1:0] res;
        int              acc_cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending transform", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_result", result, mon_e.res);
                check("sb_latency", cyc - mon_e.acc_cyc, LAT);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input logic [ACCW-1:0] exp);
        start = 1'b1;
        sb_q.push_back('{res: exp, acc_cyc: cyc});
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < LAT + 10; i++) begin
            step();
            if (done === 1'b1) break;
        end
        check(name, done, 1);
    endtask

    typedef struct {
        int               mode;
        logic [RW-1:0]    c;
        logic [NP*DW-1:0] smp;
        logic [ACCW-1:0]  exp;
    } vec_t;
    vec_t vt[7];

    logic [NP*DW-1:0] ramp, ones, corner;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NP; k++) begin
            ramp[k*DW +: DW] = DW'(k);
        end
        ones   = '1;
        corner = '0;
        corner[0*DW +: DW]  = 16'h0001;
        corner[15*DW +: DW] = 16'h8000;

        vt[0] = '{mode: 0, c: 32'h0000_0001, smp: ramp, exp: 48'h0000_0000_FFFF};
        vt[1] = '{mode: 0, c: 32'hFFFF_FFFF, smp: ramp, exp: 48'hFFFF_FFFF_0001};
        vt[2] = '{mode: 2, c: 32'h0,         smp: ramp, exp: 48'd120};
        vt[3] = '{mode: 1, c: 32'h0,         smp: ramp, exp: 48'h0000_000E_0002};
        vt[4] = '{mode: 0, c: 32'h8000_0000, smp: ramp, exp: 48'h8000_8000_0000};
        vt[5] = '{mode: 0, c: 32'h7FFF_FFFF, smp: ramp, exp: 48'h7FFF_7FFF_0001};
        vt[6] = '{mode: 1, c: 32'h0,         smp: corner, exp: 48'h0000_4000_0001};

        rst       = 1'b1;
        start     = 1'b0;
        samples   = '0;
        rom_mode  = 0;
        rom_const = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_x_bits", x_bits, 0);
        check("reset_m", m, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);

        // Table-driven transforms
        for (int i = 0; i < 7; i++) begin
            rom_mode  = vt[i].mode;
            rom_const = vt[i].c;
            samples   = vt[i].smp;
            launch(vt[i].exp);
            step();
            start   = 1'b0;
            samples = ~vt[i].smp;  // must have no effect after acceptance
            wait_done("vec_done_seen");
            check("vec_result", result, vt[i].exp);
            step();
            check("vec_idle_done", done, 0);
        end

        // Slice presentation, cycle by cycle
        rom_mode = 1;
        samples  = corner;
        launch(48'h0000_4000_0001);
        for (int c = 1; c <= LAT; c++) begin
            step();
            start = 1'b0;
            check("slice_x_bits", x_bits, (c == 2) ? 16'h0001 : (c == 17) ? 16'h8000 : 16'h0000);
            check("slice_m", m, (c == 17) ? 1 : 0);
            check("slice_busy", busy, (c >= 1 && c <= 17) ? 1 : 0);
            check("slice_done", done, (c == LAT) ? 1 : 0);
        end
        step();

        // start pulsed during SHIFT is ignored
        rom_mode  = 0;
        rom_const = 32'h1;
        launch(48'h0000_0000_FFFF);
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ign_done_seen");
        repeat (3) step();
        check("ign_busy_after", busy, 0);
        check("ign_result_held", result, 48'h0000_0000_FFFF);

        // Back-to-back: start held through DONE
        rom_mode = 2;
        samples  = ramp;
        launch(48'd120);
        step();
        start   = 1'b0;
        samples = ones;
        repeat (16) step();
        start = 1'b1;
        step();
        check("b2b_first_done", done, 1);
        sb_q.push_back('{res: 48'h0000_000F_FFF0, acc_cyc: cyc});
        step();
        start = 1'b0;
        check("b2b_load_busy", busy, 1);
        check("b2b_load_done", done, 0);
        check("b2b_load_result", result, 48'd120);
        for (int i = 0; i < LAT + 5; i++) begin
            step();
            if (done === 1'b1) break;
            check("b2b_result_held", result, 48'd120);
        end
        check("b2b_second_done", done, 1);
        check("b2b_second_result", result, 48'h0000_000F_FFF0);
        step();

        // Asynchronous reset in the middle of SHIFT
        rom_mode  = 0;
        rom_const = 32'h1;
        launch(48'h0000_0000_FFFF);
        step();
        start = 1'b0;
        repeat (5) step();
        #1 rst = 1'b1;
        #1;
        sb_q.delete();
        check("rst_mid_x_bits", x_bits, 0);
        check("rst_mid_m", m, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 0);
        step();
        rst = 1'b0;
        step();
        check("rst_after_busy", busy, 0);
        launch(48'h0000_0000_FFFF);
        step();
        start = 1'b0;
        wait_done("rst_after_done_seen");
        check("rst_after_result", result, 48'h0000_0000_FFFF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
